taxi_eth_mac_swap: RTL and testbench

Single-clock AXI4-Stream stage between the RX→TX loopback FIFO output and the 25G MAC transmit input, one instance per SFP+ channel in the TX clock domain. It swaps the Ethernet destination and source MAC addresses of every frame so looped-back traffic is addressed back to its sender. It carries a one-beat holding register to bridge the address field across the 64-bit beat boundary, and it keeps frame counters.

---
 rtl/taxi_eth_mac_swap_if.sv | 26 ++
 rtl/taxi_eth_mac_swap.sv | 242 ++++++++++++++++++++++++
 tb/tb_taxi_eth_mac_swap.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_eth_mac_swap_if.sv
// AXI4-Stream bundle shared by the MAC-swap stage and its neighbours.
// src drives a stream, snk receives one.
interface taxi_axis_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int ID_W   = 8,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_eth_mac_swap.sv
// Loopback TX stage: swaps Ethernet dst/src MAC addresses of each frame,
// bridging the 12-byte address field across the first two 64-bit beats.
module taxi_eth_mac_swap #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ID_W   = 8,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    input  logic             cfg_swap_en,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_swapped,
    output logic [CNT_W-1:0] stat_passthru
);

    if (DATA_W != 64 || KEEP_W != DATA_W / 8) begin : g_bad_width
        $error("taxi_eth_mac_swap supports only DATA_W=64, KEEP_W=8");
    end

    typedef enum logic [1:0] {HEAD0, HEAD1, BODY, TAIL} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [KEEP_W-1:0] hold_keep_q, hold_keep_d;
    logic [ID_W-1:0]   hold_id_q, hold_id_d;
    logic              hold_user_q, hold_user_d;
    logic              hold_last_q, hold_last_d;
    logic              sw_en_q, sw_en_d;
    logic              fr_sw_q, fr_sw_d;

    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [KEEP_W-1:0] m_keep_q, m_keep_d;
    logic [ID_W-1:0]   m_id_q, m_id_d;
    logic              m_user_q, m_user_d;
    logic              m_last_q, m_last_d;
    logic              m_valid_q, m_valid_d;
    logic              m_sw_q, m_sw_d;

    logic [CNT_W-1:0]  frames_q, swapped_q, passthru_q;

    logic              out_rdy;
    logic              s_rdy;
    logic              s_fire;
    logic              m_fire;
    logic              do_swap;
    logic [DATA_W-1:0] sw0, sw1;
    logic              push;
    logic              load;
    logic              load_sw;
    logic [DATA_W-1:0] push_data;

    assign out_rdy = !m_valid_q || m_axis.tready;
    assign s_fire  = s_axis.tvalid && s_rdy;
    assign m_fire  = m_valid_q && m_axis.tready;

    // hold = beat 0, s_axis = beat 1: exchange bytes 0..5 with 6..11
    assign sw0 = {hold_data_q[15:0], s_axis.tdata[31:0], hold_data_q[63:48]};
    assign sw1 = {s_axis.tdata[63:32], hold_data_q[47:16]};

    assign do_swap = sw_en_q &&
                     !(s_axis.tlast && s_axis.tkeep[3:0] != 4'hF);

    always_comb begin
        s_rdy = 1'b0;
        unique case (state_q)
            HEAD0: s_rdy = 1'b1;
            HEAD1: s_rdy = !hold_last_q && out_rdy;
            BODY:  s_rdy = out_rdy;
            TAIL:  s_rdy = out_rdy;
        endcase
        s_rdy = s_rdy && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HEAD0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HEAD0: begin
                if (s_fire) state_d = HEAD1;
            end
            HEAD1: begin
                if (hold_last_q) begin
                    if (out_rdy) state_d = HEAD0;
                end else if (s_fire) begin
                    state_d = s_axis.tlast ? TAIL : BODY;
                end
            end
            BODY: begin
                if (s_fire && s_axis.tlast) state_d = TAIL;
            end
            TAIL: begin
                if (out_rdy) state_d = s_fire ? HEAD1 : HEAD0;
            end
        endcase
    end

    always_comb begin
        push      = 1'b0;
        load      = 1'b0;
        load_sw   = 1'b0;
        push_data = hold_data_q;
        sw_en_d   = sw_en_q;
        fr_sw_d   = fr_sw_q;
        unique case (state_q)
            HEAD0: begin
                if (s_fire) begin
                    load    = 1'b1;
                    sw_en_d = cfg_swap_en;
                    fr_sw_d = 1'b0;
                end
            end
            HEAD1: begin
                if (hold_last_q) begin
                    push = out_rdy;
                end else if (s_fire) begin
                    push    = 1'b1;
                    load    = 1'b1;
                    load_sw = do_swap;
                    fr_sw_d = do_swap;
                    if (do_swap) push_data = sw0;
                end
            end
            BODY: begin
                if (s_fire) begin
                    push = 1'b1;
                    load = 1'b1;
                end
            end
            TAIL: begin
                if (out_rdy) begin
                    push = 1'b1;
                    if (s_fire) begin
                        load    = 1'b1;
                        sw_en_d = cfg_swap_en;
                        fr_sw_d = 1'b0;
                    end
                end
            end
        endcase

        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hold_id_d   = hold_id_q;
        hold_user_d = hold_user_q;
        hold_last_d = hold_last_q;
        if (load) begin
            hold_data_d = load_sw ? sw1 : s_axis.tdata;
            hold_keep_d = s_axis.tkeep;
            hold_id_d   = s_axis.tid;
            hold_user_d = s_axis.tuser[0];
            hold_last_d = s_axis.tlast;
        end

        m_valid_d = m_valid_q && !out_rdy;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_id_d    = m_id_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        m_sw_d    = m_sw_q;
        if (push) begin
            m_valid_d = 1'b1;
            m_data_d  = push_data;
            m_keep_d  = hold_keep_q;
            m_id_d    = hold_id_q;
            m_user_d  = hold_user_q;
            m_last_d  = hold_last_q;
            m_sw_d    = fr_sw_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_id_q   <= '0;
            hold_user_q <= 1'b0;
            hold_last_q <= 1'b0;
            sw_en_q     <= 1'b0;
            fr_sw_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_id_q      <= '0;
            m_user_q    <= 1'b0;
            m_last_q    <= 1'b0;
            m_sw_q      <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_id_q   <= hold_id_d;
            hold_user_q <= hold_user_d;
            hold_last_q <= hold_last_d;
            sw_en_q     <= sw_en_d;
            fr_sw_q     <= fr_sw_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_id_q      <= m_id_d;
            m_user_q    <= m_user_d;
            m_last_q    <= m_last_d;
            m_sw_q      <= m_sw_d;
        end
    end

    // frame statistics count on the output tlast handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames_q   <= '0;
            swapped_q  <= '0;
            passthru_q <= '0;
        end else if (m_fire && m_last_q) begin
            frames_q <= frames_q + CNT_W'(1);
            if (m_sw_q) swapped_q <= swapped_q + CNT_W'(1);
            else passthru_q <= passthru_q + CNT_W'(1);
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tid    = m_id_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = m_last_q;

    assign stat_frames   = frames_q;
    assign stat_swapped  = swapped_q;
    assign stat_passthru = passthru_q;

endmodule

// File: tb/tb_taxi_eth_mac_swap.sv
// Bench for taxi_eth_mac_swap: byte-level swap model, scoreboard,
// directed frames, back-to-back run, random backpressure and mid-frame reset.
module tb_taxi_eth_mac_swap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_swap_en = 1'b0;
    logic        m_rdy = 1'b1;
    logic [31:0] stat_frames, stat_swapped, stat_passthru;

    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .ID_W(8), .USER_W(1)) s_if ();
    taxi_axis_if #(.DATA_W(64), .KEEP_W(8), .ID_W(8), .USER_W(1)) m_if ();

    assign m_if.tready = m_rdy;

    taxi_eth_mac_swap #(
        .DATA_W(64), .KEEP_W(8), .ID_W(8), .CNT_W(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .cfg_swap_en  (cfg_swap_en),
        .stat_frames  (stat_frames),
        .stat_swapped (stat_swapped),
        .stat_passthru(stat_passthru)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  id;
        logic        u;
        logic        l;
        bit          sw;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] obs_q[$];
    logic [63:0] fr_data[0:31];
    int          n_chk = 0;
    int          n_pass = 0;
    int          rdy_pct = 100;
    int unsigned mdl_frames = 0, mdl_sw = 0, mdl_pt = 0;
    bit          bb_on = 0;
    int          bb_first = 0, bb_last = 0, bb_beats = 0;
    int          cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        m_rdy = ($urandom_range(0, 99) < rdy_pct);
    end

    bit          prev_stall = 0;
    logic [63:0] pd;
    logic [17:0] pside;

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
            exp_q.delete();
            mdl_frames = 0;
            mdl_sw = 0;
            mdl_pt = 0;
        end else begin
            chk("stat_frames", 64'(stat_frames), 64'(mdl_frames));
            chk("stat_swapped", 64'(stat_swapped), 64'(mdl_sw));
            chk("stat_passthru", 64'(stat_passthru), 64'(mdl_pt));
            if (prev_stall) begin
                chk("stall_valid", 64'(m_if.tvalid), 64'd1);
                chk("stall_data", m_if.tdata, pd);
                chk("stall_side", 64'({m_if.tkeep, m_if.tid, m_if.tuser,
                                      m_if.tlast}), 64'(pside));
            end
            if (m_if.tvalid && m_if.tready) begin
                obs_q.push_back(m_if.tdata);
                if (bb_on) begin
                    if (bb_beats == 0) bb_first = cyc;
                    bb_last = cyc;
                    bb_beats++;
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 64'(m_if.tvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_if.tdata, e.d);
                    chk("tkeep", 64'(m_if.tkeep), 64'(e.k));
                    chk("tid", 64'(m_if.tid), 64'(e.id));
                    chk("tuser", 64'(m_if.tuser), 64'(e.u));
                    chk("tlast", 64'(m_if.tlast), 64'(e.l));
                    if (e.l) begin
                        mdl_frames++;
                        if (e.sw) mdl_sw++;
                        else mdl_pt++;
                    end
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            pd = m_if.tdata;
            pside = {m_if.tkeep, m_if.tid, m_if.tuser, m_if.tlast};
        end
    end

    // Expected output of one frame: exchange byte fields 0..5 and 6..11
    task automatic model_frame(input int n, input logic [7:0] klast,
                               input logic [7:0] id, input logic bad,
                               input logic sw);
        int          len;
        bit          do_sw;
        logic [7:0]  b[0:15];
        logic [7:0]  t;
        logic [63:0] sd[0:1];
        beat_t       e;
        len = 8 * (n - 1) + $countones(klast);
        do_sw = sw && (len >= 12);
        for (int i = 0; i < 16; i++) b[i] = fr_data[i / 8][8 * (i % 8) +: 8];
        for (int i = 0; i < 6; i++) begin
            t = b[i];
            b[i] = b[i + 6];
            b[i + 6] = t;
        end
        for (int i = 0; i < 16; i++) sd[i / 8][8 * (i % 8) +: 8] = b[i];
        for (int i = 0; i < n; i++) begin
            e.d  = (do_sw && i < 2) ? sd[i] : fr_data[i];
            e.k  = (i == n - 1) ? klast : 8'hFF;
            e.id = id;
            e.u  = (i == n - 1) ? bad : 1'b0;
            e.l  = (i == n - 1);
            e.sw = do_sw;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int c);
        s_if.tvalid = 1'b0;
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic [7:0] id, input logic u,
                              input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tid    = id;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!s_if.tready) chk("accept_timeout", 64'(s_if.tready), 64'd1);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] klast,
                              input logic [7:0] id, input logic bad,
                              input logic sw, input int gap_pct,
                              input bit toggle);
        model_frame(n, klast, id, bad, sw);
        cfg_swap_en = sw;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            drive_beat(fr_data[i], (i == n - 1) ? klast : 8'hFF, id,
                       (i == n - 1) ? bad : 1'b0, (i == n - 1));
            if (i == 0 && toggle) cfg_swap_en = ~sw;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // dst 02:00:00:00:00:01, src 02:00:00:00:00:02, type 0x0800, payload i
    task automatic build_a(input int nbytes);
        logic [7:0] by[0:255];
        for (int i = 0; i < nbytes; i++) by[i] = 8'(i);
        by[0] = 8'h02; by[1] = 8'h00; by[2] = 8'h00;
        by[3] = 8'h00; by[4] = 8'h00; by[5] = 8'h01;
        by[6] = 8'h02; by[7] = 8'h00; by[8] = 8'h00;
        by[9] = 8'h00; by[10] = 8'h00; by[11] = 8'h02;
        by[12] = 8'h08; by[13] = 8'h00;
        for (int i = 0; i < nbytes; i++) fr_data[i / 8][8 * (i % 8) +: 8] = by[i];
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tid    = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 32; i++) fr_data[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_tdata", m_if.tdata, 64'd0);
        chk("rst_side", 64'({m_if.tkeep, m_if.tid, m_if.tuser, m_if.tlast}),
            64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_stats", 64'({stat_frames, stat_swapped}), 64'd0);
        chk("rst_passthru", 64'(stat_passthru), 64'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // swapped 64-byte frame
        obs_q.delete();
        build_a(64);
        send_frame(8, 8'hFF, 8'h11, 1'b0, 1'b1, 0, 0);
        wait_drain();
        chk("a_beats", 64'(obs_q.size()), 64'd8);
        chk("a_out0", obs_q[0], 64'h0002_0200_0000_0002);
        chk("a_out1", obs_q[1], 64'h0F0E_0008_0100_0000);
        chk("a_out2", obs_q[2], 64'h1716_1514_1312_1110);
        chk("a_out7", obs_q[7], 64'h3F3E_3D3C_3B3A_3938);
        chk("a_swapped", 64'(stat_swapped), 64'd1);
        chk("a_frames", 64'(stat_frames), 64'd1);

        // same frame, swap disabled
        obs_q.delete();
        send_frame(8, 8'hFF, 8'h12, 1'b0, 1'b0, 0, 0);
        wait_drain();
        chk("b_out0", obs_q[0], 64'h0002_0100_0000_0002);
        chk("b_out1", obs_q[1], 64'h0F0E_0008_0200_0000);
        chk("b_passthru", 64'(stat_passthru), 64'd1);

        // single-beat frame: output one cycle after accept
        obs_q.delete();
        fr_data[0] = 64'h1122_3344_5566_7788;
        send_frame(1, 8'hFF, 8'h13, 1'b0, 1'b1, 0, 0);
        @(negedge clk);
        chk("lat1_early", 64'(m_if.tvalid), 64'd0);
        @(negedge clk);
        chk("lat1_valid", 64'(m_if.tvalid), 64'd1);
        chk("lat1_data", m_if.tdata, 64'h1122_3344_5566_7788);
        chk("lat1_last", 64'(m_if.tlast), 64'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // 10-byte frame stays unmodified
        obs_q.delete();
        fr_data[0] = 64'hA8A7_A6A5_A4A3_A2A1;
        fr_data[1] = 64'h0000_0000_0000_B2B1;
        send_frame(2, 8'h03, 8'h14, 1'b0, 1'b1, 0, 0);
        wait_drain();
        chk("c10_out0", obs_q[0], 64'hA8A7_A6A5_A4A3_A2A1);
        chk("c_frames", 64'(stat_frames), 64'd4);
        chk("c_swapped", 64'(stat_swapped), 64'd1);
        chk("c_passthru", 64'(stat_passthru), 64'd3);

        // 1000 back-to-back 64-byte frames
        bb_on = 1;
        for (int f = 0; f < 1000; f++) begin
            for (int j = 0; j < 8; j++) fr_data[j] = {$urandom, $urandom};
            send_frame(8, 8'hFF, 8'(f), 1'b0, 1'($urandom_range(0, 1)), 0, 0);
        end
        wait_drain();
        bb_on = 0;
        chk("bb_beats", 64'(bb_beats), 64'd8000);
        chk("bb_span", 64'(bb_last - bb_first + 1), 64'd8000);
        chk("bb_frames", 64'(stat_frames), 64'd1004);

        // random lengths, gaps, backpressure, bad frames, mid-frame cfg
        rdy_pct = 70;
        for (int f = 0; f < 300; f++) begin
            int          n;
            logic [7:0]  kl;
            n  = $urandom_range(1, 24);
            kl = 8'hFF >> $urandom_range(0, 7);
            for (int j = 0; j < n; j++) fr_data[j] = {$urandom, $urandom};
            send_frame(n, kl, 8'($urandom), 1'($urandom_range(0, 99) < 20),
                       1'($urandom_range(0, 1)), 25, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        rdy_pct = 100;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // reset during beat 3 of a 128-byte frame
        build_a(128);
        model_frame(16, 8'hFF, 8'h21, 1'b0, 1'b1);
        cfg_swap_en = 1'b1;
        for (int i = 0; i < 3; i++)
            drive_beat(fr_data[i], 8'hFF, 8'h21, 1'b0, 1'b0);
        s_if.tdata  = fr_data[3];
        s_if.tvalid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        chk("rstmid_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rstmid_frames", 64'(stat_frames), 64'd0);
        chk("rstmid_sw_pt", 64'({stat_swapped, stat_passthru}), 64'd0);
        @(posedge clk);
        #1;
        obs_q.delete();
        build_a(64);
        send_frame(8, 8'hFF, 8'h22, 1'b0, 1'b1, 0, 0);
        wait_drain();
        chk("post_out0", obs_q[0], 64'h0002_0200_0000_0002);
        chk("post_out1", obs_q[1], 64'h0F0E_0008_0100_0000);
        chk("post_swapped", 64'(stat_swapped), 64'd1);
        chk("post_frames", 64'(stat_frames), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
